// File: rtl/bk_nibble_sequencer.sv
// Feeds a WIDTH-bit add through the 4-bit slice one nibble per pass, LSB first, with a rippled carry.
// Result is valid 3*NIB cycles after accept and is held in DONE until OUT_READY; IN_READY only in IDLE.
module bk_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    input  logic             OP_CIN,
    output logic [3:0]       ADD_A,
    output logic [3:0]       ADD_B,
    output logic             ADD_CIN,
    input  logic [3:0]       ADD_S,
    input  logic [4:0]       ADD_COUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY_OUT,
    output logic             BUSY
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("bk_nibble_sequencer: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, WAIT1, WAIT2, CAPT, DONE} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d, k_nxt;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [3:0]       add_a_q, add_a_d, add_b_q, add_b_d;
    logic             add_cin_q, add_cin_d;
    logic             carry_out_q, carry_out_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       nib_a_nxt, nib_b_nxt;
    logic             unused_cout;

    // Only the nibble carry-out matters; the slice's internal carries are not needed.
    assign unused_cout = ^ADD_COUT[3:0];

    always_comb begin
        k_nxt     = k_q + 1'b1;
        nib_a_nxt = '0;
        nib_b_nxt = '0;
        for (int i = 0; i < NIB; i++) begin
            if (k_nxt == KW'(i)) begin
                nib_a_nxt = a_q[4*i +: 4];
                nib_b_nxt = b_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        carry_out_d = carry_out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    a_d         = OP_A;
                    b_d         = OP_B;
                    add_a_d     = OP_A[3:0];
                    add_b_d     = OP_B[3:0];
                    add_cin_d   = OP_CIN;
                    k_d         = '0;
                    sum_d       = '0;
                    carry_out_d = 1'b0;
                    state_d     = WAIT1;
                end
            end
            WAIT1: state_d = WAIT2;
            WAIT2: state_d = CAPT;
            CAPT: begin
                for (int i = 0; i < NIB; i++) begin
                    if (k_q == KW'(i)) begin
                        sum_d[4*i +: 4] = ADD_S;
                    end
                end
                if (k_q == KW'(NIB - 1)) begin
                    carry_out_d = ADD_COUT[4];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    add_a_d   = nib_a_nxt;
                    add_b_d   = nib_b_nxt;
                    add_cin_d = ADD_COUT[4];
                    k_d       = k_nxt;
                    state_d   = WAIT1;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            carry_out_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            carry_out_q <= carry_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign BUSY      = (state_q != IDLE);
    assign ADD_A     = add_a_q;
    assign ADD_B     = add_b_q;
    assign ADD_CIN   = add_cin_q;
    assign OUT_VALID = out_valid_q;
    assign SUM       = sum_q;
    assign CARRY_OUT = carry_out_q;
endmodule
